// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - sync, debounce and one-hot press pulses for three keys (optional auto-repeat: PUSHBUTTON_AUTO_REPEAT_EN)
module pushbutton_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] buttons_raw,
  output logic [2:0] pushbuttons,
  output logic [2:0] button_level
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  // Out-of-range settings would break debounce timing or let repeats pulse on
  // consecutive cycles, so reject them at elaboration.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFFFFFF ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("pushbutton_conditioner: parameter out of range");
  end

  logic [2:0] norm;
  logic [2:0] sync1;
  logic [2:0] s;
  logic [2:0] held;
  logic [2:0] req;
  logic [2:0] req_q;

  // Normalise so that 1 always means pressed, whatever the board wiring.
  assign norm = (ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;

  // Two-flop synchroniser per key; s is the only copy the FSMs look at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b000;
      s     <= 3'b000;
    end else begin
      sync1 <= norm;
      s     <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_t      state;
    state_t      state_nx;
    logic [23:0] cnt;
    logic [23:0] cnt_nx;
    logic        press_req;
    logic        rep_req;

    // Debounce state and stability counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= 24'd0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    // Accept a level change only after DEBOUNCE_CYCLES identical samples.
    always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      press_req = 1'b0;
      case (state)
        IDLE: begin
          if (s[i]) begin
            state_nx = PRESS_WAIT;
            cnt_nx   = 24'd1;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_nx = IDLE;
            cnt_nx   = 24'd0;
          end else if (cnt == DB_LAST) begin
            state_nx  = PRESSED;
            cnt_nx    = 24'd0;
            press_req = 1'b1;
          end else if (cnt != 24'hFFFFFF) begin
            cnt_nx = cnt + 24'd1;
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = 24'd1;
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_nx = PRESSED;
            cnt_nx   = 24'd0;
          end else if (cnt == DB_LAST) begin
            state_nx = IDLE;
            cnt_nx   = 24'd0;
          end else if (cnt != 24'hFFFFFF) begin
            cnt_nx = cnt + 24'd1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = 24'd0;
        end
      endcase
    end

`ifdef PUSHBUTTON_AUTO_REPEAT_EN
    localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rcnt;
    logic        rstarted;

    // A repeat fires only while the key stays in PRESSED this cycle and next.
    always_comb begin
      rep_req = 1'b0;
      if (state == PRESSED && state_nx == PRESSED) begin
        rep_req = rstarted ? (rcnt == RP_LAST) : (rcnt == RD_LAST);
      end
    end

    // Repeat timer: restarts on every pulse, cleared whenever PRESSED is left.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rcnt     <= 32'd0;
        rstarted <= 1'b0;
      end else if (state != PRESSED || state_nx != PRESSED) begin
        rcnt     <= 32'd0;
        rstarted <= 1'b0;
      end else if (rep_req) begin
        rcnt     <= 32'd0;
        rstarted <= 1'b1;
      end else if (rcnt != 32'hFFFFFFFF) begin
        rcnt <= rcnt + 32'd1;
      end
    end
`else
    assign rep_req = 1'b0;
`endif

    assign held[i] = (state == PRESSED) || (state == RELEASE_WAIT);
    assign req[i]  = press_req | rep_req;
  end

  // Register requests and levels, then pick the lowest-index request so the
  // pulse output is one-hot; losing requests are simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= 3'b000;
      pushbuttons  <= 3'b000;
      button_level <= 3'b000;
    end else begin
      req_q        <= req;
      button_level <= held;
      if (req_q[0]) begin
        pushbuttons <= 3'b001;
      end else if (req_q[1]) begin
        pushbuttons <= 3'b010;
      end else if (req_q[2]) begin
        pushbuttons <= 3'b100;
      end else begin
        pushbuttons <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - scoreboard bench for pushbutton_conditioner
module tb_pushbutton_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] buttons_raw;
  logic [2:0] pushbuttons;
  logic [2:0] button_level;

  typedef struct {
    int         at;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   tests  = 0;
  int   fails  = 0;

  pushbutton_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons_raw (buttons_raw),
    .pushbuttons (pushbuttons),
    .button_level(button_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #1000000;
    $display("FAIL timeout edge=%0d", edge_n);
    $fatal(1, "timeout");
  end

  // Pulse expected in the cycle following the posedge just passed.
  function automatic logic [2:0] sb_expect();
    exp_t e;
    if (sb.size() != 0 && sb[0].at == edge_n) begin
      e = sb.pop_front();
      return e.val;
    end
    return 3'b000;
  endfunction

  task automatic tick(output logic [2:0] pb, output logic [2:0] lvl);
    @(negedge clk);
    pb  = pushbuttons;
    lvl = button_level;
  endtask

  task automatic test_reset();
    logic [2:0] pb, lvl, ev, el;
    int p, r;
    tick(pb, lvl);
    tests++;
    if ({pb, lvl} !== 6'b0) begin
      fails++;
      $display("FAIL reset_state got pb=%b lvl=%b want 000/000", pb, lvl);
    end
    buttons_raw = 3'b110;
    tick(pb, lvl);
    reset = 1'b0;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b001});
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= p + 6) ? 3'b001 : 3'b000;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL reset_release e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (pushbuttons !== 3'b000 || button_level !== 3'b000) begin
      fails++;
      $display("FAIL reset_async got pb=%b lvl=%b want 000/000", pushbuttons, button_level);
    end
    tick(pb, lvl);
    tick(pb, lvl);
    reset = 1'b0;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b001});
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= p + 6) ? 3'b001 : 3'b000;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL reset_midpress e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    buttons_raw = 3'b111;
    r = edge_n + 1;
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= r + 6) ? 3'b000 : 3'b001;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL release_latency e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] pb, lvl, ev, el;
    int p, r;
    buttons_raw = 3'b110;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b001});
    for (int k = 0; k < 30; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= p + 6) ? 3'b001 : 3'b000;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL clean_press e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    buttons_raw = 3'b111;
    r = edge_n + 1;
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= r + 6) ? 3'b000 : 3'b001;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL clean_release e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] pb, lvl, ev, el;
    int p;
    for (int b = 0; b < 15; b++) begin
      buttons_raw = ((b % 3) == 2) ? 3'b111 : 3'b101;
      tick(pb, lvl);
      ev = sb_expect();
      tests++;
      if (pb !== ev || lvl !== 3'b000) begin
        fails++;
        $display("FAIL bounce_reject e=%0d got pb=%b lvl=%b want %b/000", edge_n, pb, lvl, ev);
      end
    end
    buttons_raw = 3'b101;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b010});
    for (int k = 0; k < 12; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= p + 6) ? 3'b010 : 3'b000;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL bounce_accept e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    buttons_raw = 3'b111;
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      tests++;
      if (pb !== ev) begin
        fails++;
        $display("FAIL bounce_release e=%0d got pb=%b want %b", edge_n, pb, ev);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] pb, lvl, ev, el;
    int p, r;
    buttons_raw = 3'b010;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b001});
    for (int k = 0; k < 12; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= p + 6) ? 3'b101 : 3'b000;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL simultaneous e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    buttons_raw = 3'b111;
    r = edge_n + 1;
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= r + 6) ? 3'b000 : 3'b101;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL simultaneous_release e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [2:0] pb, lvl, ev, el;
    int p;
    buttons_raw = 3'b110;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b001});
    for (int k = 0; k < 24; k++) begin
      if (k == 10) buttons_raw = 3'b111;
      if (k == 12) buttons_raw = 3'b110;
      tick(pb, lvl);
      ev = sb_expect();
      el = (edge_n >= p + 6) ? 3'b001 : 3'b000;
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL release_bounce e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    buttons_raw = 3'b111;
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      tests++;
      if (pb !== ev) begin
        fails++;
        $display("FAIL release_bounce_end e=%0d got pb=%b want %b", edge_n, pb, ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] pb, lvl, ev, el;
    int p;
    buttons_raw = 3'b101;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b010});
    sb.push_back('{p + 7, 3'b001});
    for (int k = 0; k < 14; k++) begin
      tick(pb, lvl);
      if (k == 0) buttons_raw = 3'b100;
      ev = sb_expect();
      el = ((edge_n >= p + 6) ? 3'b010 : 3'b000) | ((edge_n >= p + 7) ? 3'b001 : 3'b000);
      tests++;
      if (pb !== ev || lvl !== el) begin
        fails++;
        $display("FAIL back_to_back e=%0d got pb=%b lvl=%b want %b/%b", edge_n, pb, lvl, ev, el);
      end
    end
    buttons_raw = 3'b111;
    for (int k = 0; k < 10; k++) begin
      tick(pb, lvl);
      ev = sb_expect();
      tests++;
      if (pb !== ev) begin
        fails++;
        $display("FAIL back_to_back_release e=%0d got pb=%b want %b", edge_n, pb, ev);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [2:0] pb, lvl, ev;
    int p;
    buttons_raw = 3'b011;
    p = edge_n + 1;
    sb.push_back('{p + 6, 3'b100});
`ifdef PUSHBUTTON_AUTO_REPEAT_EN
    for (int j = 0; j < 5; j++) sb.push_back('{p + 26 + 8 * j, 3'b100});
`endif
    for (int k = 0; k < 80; k++) begin
      if (k == 60) buttons_raw = 3'b111;
      tick(pb, lvl);
      ev = sb_expect();
      tests++;
      if (pb !== ev) begin
        fails++;
        $display("FAIL long_hold e=%0d got pb=%b want %b", edge_n, pb, ev);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    buttons_raw = 3'b111;
    repeat (3) @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release_bounce();
    test_back_to_back();
    test_long_hold();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
